// File: rtl/tone_pkg.sv
// tone_pkg: shared note definitions for the tone generator / tone decoder pair.
//   - A-major scale note frequencies (Hz) and index encoding (0=A .. 6=G#)
//   - decoder FSM state type
//   - nominal period (clk cycles) from clock and note frequency
package tone_pkg;

    localparam int NUM_NOTES = 7;

    localparam logic [2:0] NOTE_A  = 3'd0;
    localparam logic [2:0] NOTE_B  = 3'd1;
    localparam logic [2:0] NOTE_CS = 3'd2;
    localparam logic [2:0] NOTE_D  = 3'd3;
    localparam logic [2:0] NOTE_E  = 3'd4;
    localparam logic [2:0] NOTE_FS = 3'd5;
    localparam logic [2:0] NOTE_GS = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    function automatic int note_freq(input int idx);
        case (idx)
            0:       return 440;
            1:       return 493;
            2:       return 554;
            3:       return 587;
            4:       return 659;
            5:       return 740;
            6:       return 830;
            default: return 1;
        endcase
    endfunction

    // Truncating division, same rounding the tone generator uses.
    function automatic int note_period(input int clk_hz, input int idx);
        return clk_hz / note_freq(idx);
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// tone_edge_sync: 2-FF synchronizer, optional glitch filter, registered
// rising-edge pulse.
//   clk, reset_n : clock, async active-low reset
//   din          : asynchronous input
//   rise         : one-cycle pulse, 3 cycles after din rises (filter off)
// Optional feature macro: TONE_DECODER_GLITCH_FILTER_EN -- level must hold
// FILTER_CYCLES consecutive cycles before it is passed on (+FILTER_CYCLES latency).
module tone_edge_sync #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("FILTER_CYCLES must be >= 1");
    end

    logic s1, s2, lvl, lvl_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    logic          flt;
    logic [FW-1:0] fcnt;

    // fcnt counts consecutive cycles s2 disagrees with flt; any agreement restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt  <= 1'b0;
            fcnt <= '0;
        end else if (s2 == flt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
            flt  <= s2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end
    assign lvl = flt;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_d <= 1'b0;
            rise  <= 1'b0;
        end else begin
            lvl_d <= lvl;
            rise  <= lvl & ~lvl_d;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a square-wave tone, classifies it
// against the seven A-major notes and reports a locked note.
//   clk, reset_n  : clock, async active-low reset
//   tone_in       : asynchronous square-wave input
//   note_valid    : high while a note is locked
//   note_index    : locked note 0=A .. 6=G#, holds when not valid
//   note_change   : one-cycle pulse on each entry into LOCKED
//   period_cycles : last measured period in clk cycles
// Optional feature macro: TONE_DECODER_GLITCH_FILTER_EN (see tone_edge_sync).
module tone_decoder
    import tone_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int TOL           = 2000,
    parameter int LOCK_COUNT    = 3,
    parameter int TIMEOUT       = 200_000,
    parameter int FILTER_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tone_in,
    output logic        note_valid,
    output logic [2:0]  note_index,
    output logic        note_change,
    output logic [31:0] period_cycles
);

    localparam logic [3:0]  LOCK_N = 4'(LOCK_COUNT);
    localparam logic [31:0] TMO    = 32'(TIMEOUT);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
        $error("LOCK_COUNT must be 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    logic        rise;
    state_e      state;
    logic [31:0] cnt;
    logic [31:0] meas;
    logic [3:0]  match_cnt, nxt_cnt;
    logic [2:0]  cand, nxt_cand, cls;
    logic        cls_valid;
    logic        timeout;
    logic [NUM_NOTES-1:0] hit;

    tone_edge_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (tone_in),
        .rise    (rise)
    );

    assign meas    = cnt + 32'd1;
    assign timeout = (cnt == TMO);

    // Window per note; frequencies ascend so periods descend and only
    // neighbours can collide.
    for (genvar k = 0; k < NUM_NOTES; k++) begin : g_win
        localparam int PK = note_period(CLOCK_FREQ, k);
        assign hit[k] = (meas >= 32'(PK - TOL)) && (meas <= 32'(PK + TOL));
        if (k > 0) begin : g_chk
            if (note_period(CLOCK_FREQ, k - 1) - PK <= 2 * TOL) begin : g_overlap
                $error("tone_decoder: classification windows overlap");
            end
        end
    end

    always_comb begin
        cls_valid = |hit;
        cls       = '0;
        for (int k = NUM_NOTES - 1; k >= 0; k--)
            if (hit[k]) cls = 3'(k);
    end

    // Candidate update on an edge; from LOCKED the first branch can never
    // apply because a matching class stays locked.
    always_comb begin
        if (cls_valid && cls == cand && match_cnt != 4'd0) begin
            nxt_cand = cand;
            nxt_cnt  = match_cnt + 4'd1;
        end else begin
            nxt_cand = cls;
            nxt_cnt  = cls_valid ? 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            match_cnt     <= '0;
            cand          <= '0;
            note_valid    <= 1'b0;
            note_index    <= '0;
            note_change   <= 1'b0;
            period_cycles <= '0;
        end else begin
            note_change <= 1'b0;

            if (rise) begin
                cnt           <= '0;
                period_cycles <= meas;
            end else if (cnt < TMO) begin
                cnt <= cnt + 32'd1;
            end

            // Edge takes priority over timeout in the same cycle.
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state     <= ST_MEASURE;
                        cand      <= '0;
                        match_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        cand      <= nxt_cand;
                        match_cnt <= nxt_cnt;
                        if (nxt_cnt == LOCK_N) begin
                            state       <= ST_LOCKED;
                            note_valid  <= 1'b1;
                            note_index  <= nxt_cand;
                            note_change <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        if (!(cls_valid && cls == note_index)) begin
                            state      <= ST_MEASURE;
                            cand       <= nxt_cand;
                            match_cnt  <= nxt_cnt;
                            note_valid <= 1'b0;
                        end
                    end else if (timeout) begin
                        state      <= ST_IDLE;
                        note_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    note_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed bench for tone_decoder with a scaled-down clock
// so note periods are ~500..1000 cycles.
// At CLOCK_FREQ=440000: A=1000 B=892 C#=794 D=749 E=667 F#=594 G#=530, TOL=20.
module tb_tone_decoder;
    import tone_pkg::*;

    localparam int CF   = 440_000;
    localparam int TOLC = 20;
    localparam int TMO  = 2000;
    localparam int FILT = 8;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
    localparam int LAT  = 4 + FILT;
`else
    localparam int LAT  = 4;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tone_in = 1'b0;
    logic        note_valid;
    logic [2:0]  note_index;
    logic        note_change;
    logic [31:0] period_cycles;

    int n_vec = 0;
    int n_err = 0;
    int chg_cnt = 0;
    logic prev_chg = 1'b0;
    logic dbl = 1'b0;

    tone_decoder #(
        .CLOCK_FREQ(CF), .TOL(TOLC), .LOCK_COUNT(3),
        .TIMEOUT(TMO), .FILTER_CYCLES(FILT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tone_in       (tone_in),
        .note_valid    (note_valid),
        .note_index    (note_index),
        .note_change   (note_change),
        .period_cycles (period_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (note_change) chg_cnt <= chg_cnt + 1;
        if (note_change && prev_chg) dbl <= 1'b1;
        prev_chg <= note_change;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hi(input int n);
        tone_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic lo(input int n);
        tone_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic period(input int p);
        hi(p / 2);
        lo(p - p / 2);
    endtask

    // rise_pre + one caller tick + rise_post == one full period p
    task automatic rise_pre();
        tone_in = 1'b1;
        repeat (LAT - 1) tick();
    endtask

    task automatic rise_post(input int p);
        repeat (p / 2 - LAT) tick();
        lo(p - p / 2);
    endtask

    initial begin
        // reset state
        repeat (5) tick();
        chk("rst_valid",  32'(note_valid), 32'd0);
        chk("rst_index",  32'(note_index), 32'd0);
        chk("rst_change", 32'(note_change), 32'd0);
        chk("rst_period", period_cycles, 32'd0);
        chk("rst_state",  32'(dut.state), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (5) tick();

        // A: lock at 4th rise, exactly LAT cycles after it
        repeat (3) period(1000);
        rise_pre();
        chk("a_pre_valid", 32'(note_valid), 32'd0);
        tick();
        chk("a_valid",  32'(note_valid), 32'd1);
        chk("a_index",  32'(note_index), 32'(NOTE_A));
        chk("a_change", 32'(note_change), 32'd1);
        chk("a_period", period_cycles, 32'd1000);
        rise_post(1000);
        period(1000);
        chk("a_hold_valid",  32'(note_valid), 32'd1);
        chk("a_hold_change", 32'(note_change), 32'd0);
        chk("a_chg_cnt",     32'(chg_cnt), 32'd1);

        // A -> E: first E rise measures 1000 (still A), next one drops lock
        period(667);
        rise_pre();
        chk("e_pre_valid", 32'(note_valid), 32'd1);
        tick();
        chk("e_drop_valid",  32'(note_valid), 32'd0);
        chk("e_drop_period", period_cycles, 32'd667);
        rise_post(667);
        period(667);
        rise_pre();
        chk("e_pre2_valid", 32'(note_valid), 32'd0);
        tick();
        chk("e_valid",  32'(note_valid), 32'd1);
        chk("e_index",  32'(note_index), 32'(NOTE_E));
        chk("e_change", 32'(note_change), 32'd1);
        rise_post(667);
        chk("e_chg_cnt", 32'(chg_cnt), 32'd2);

        // silence long enough to time out, then a between-windows period
        lo(TMO + 10);
        chk("to1_valid", 32'(note_valid), 32'd0);
        chk("to1_state", 32'(dut.state), 32'(ST_IDLE));
        for (int i = 0; i < 10; i++) begin
            period(840);
            chk("gap_valid", 32'(note_valid), 32'd0);
        end
        chk("gap_period", period_cycles, 32'd840);

        // G#: lock, then hold low until timeout
        repeat (3) period(530);
        rise_pre();
        tick();
        chk("gs_valid", 32'(note_valid), 32'd1);
        chk("gs_index", 32'(note_index), 32'(NOTE_GS));
        tone_in = 1'b0;
        repeat (TMO) tick();
        chk("gs_to_hold", 32'(note_valid), 32'd1);
        tick();
        chk("gs_to_drop",  32'(note_valid), 32'd0);
        chk("gs_to_state", 32'(dut.state), 32'(ST_IDLE));
        chk("gs_to_index", 32'(note_index), 32'(NOTE_GS));

        // D: lock, reset mid-lock, relock needs 4 fresh edges
        repeat (3) period(749);
        rise_pre();
        tick();
        chk("d_valid", 32'(note_valid), 32'd1);
        chk("d_index", 32'(note_index), 32'(NOTE_D));
        rise_post(749);
        hi(100);
        tone_in = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid",  32'(note_valid), 32'd0);
        chk("mrst_index",  32'(note_index), 32'd0);
        chk("mrst_change", 32'(note_change), 32'd0);
        chk("mrst_period", period_cycles, 32'd0);
        repeat (5) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        repeat (3) period(749);
        rise_pre();
        chk("d2_pre_valid", 32'(note_valid), 32'd0);
        tick();
        chk("d2_valid", 32'(note_valid), 32'd1);
        chk("d2_index", 32'(note_index), 32'(NOTE_D));
        rise_post(749);

        // A again, then a 3-cycle high glitch in the low half
        repeat (3) period(1000);
        rise_pre();
        tick();
        chk("a2_valid", 32'(note_valid), 32'd1);
        chk("a2_index", 32'(note_index), 32'(NOTE_A));
        rise_post(1000);
        hi(500);
        lo(200);
        hi(3);
        lo(297);
        rise_pre();
        tick();
`ifdef TONE_DECODER_GLITCH_FILTER_EN
        chk("glitch_valid",  32'(note_valid), 32'd1);
        chk("glitch_index",  32'(note_index), 32'(NOTE_A));
        chk("glitch_period", period_cycles, 32'd1000);
`else
        chk("glitch_valid",  32'(note_valid), 32'd0);
        chk("glitch_period", period_cycles, 32'd300);
`endif
        rise_post(1000);

        chk("no_double_change", 32'(dbl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
